// File: rtl/flash_word_fetch.sv
// ----------------------------------------------------------------------------
// flash_word_fetch
//
// Bridges a CPU-side 32-bit word-read port onto the 16-bit flash H-bus.
// Each word read is split into two halfword accesses (low then high). The
// halves are assembled into one word and returned on a valid/ready response
// port. A single-entry word cache lets a repeated fetch of the same word
// complete without touching the flash.
//
// Ports
//   Hclock       clock, rising edge
//   Hreset       asynchronous active-high reset
//   req_valid    word read request
//   req_address  byte address; bits [22:2] select word N
//   req_ready    request accepted when req_valid && req_ready at an edge
//   resp_valid   response available
//   resp_ready   consumer takes the response
//   resp_data    assembled word {hw[2N+1], hw[2N]}, 0 on error
//   resp_error   flash reported an error for this request
//   Hselect      flash select
//   ready        address strobe, always equal to Hselect
//   Haddress     flash address; halfword index is Haddress[23:2]
//   Hwrite       constant 0
//   Hsize        constant 0
//   Hwritedata   constant 0
//   Hreaddata    flash read data, only [15:0] used
//   Hready       flash data valid
//   Hresponse    flash error, meaningful only while Hready is high
// ----------------------------------------------------------------------------
module flash_word_fetch (
    input  logic        Hclock,
    input  logic        Hreset,
    input  logic        req_valid,
    input  logic [23:0] req_address,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic        Hselect,
    output logic        ready,
    output logic [23:0] Haddress,
    output logic        Hwrite,
    output logic        Hsize,
    output logic [31:0] Hwritedata,
    input  logic [31:0] Hreaddata,
    input  logic        Hready,
    input  logic        Hresponse
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        DATA_LO,
        DATA_HI,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [20:0] word_idx;
    logic [15:0] lo_half;

    logic        cache_valid;
    logic [20:0] cache_tag;
    logic [31:0] cache_data;

    logic [31:0] resp_data_q;
    logic        resp_error_q;

    logic [20:0] req_word;
    logic        accept;
    logic        cache_hit;
    logic        flash_ok;
    logic        flash_err;

    logic [23:0] addr_lo;
    logic [23:0] addr_hi;

    // Address bits that do not take part in word selection, and the unused
    // upper half of the flash data bus.
    logic        unused_bits;
    assign unused_bits = ^{req_address[23], req_address[1:0], Hreaddata[31:16]};

    assign req_word  = req_address[22:2];
    assign accept    = (state == IDLE) && req_valid;
    assign cache_hit = cache_valid && (cache_tag == req_word);
    assign flash_ok  = Hready && !Hresponse;
    assign flash_err = Hready && Hresponse;

    assign addr_lo   = {1'b0, word_idx, 1'b0, 2'b00};
    assign addr_hi   = {1'b0, word_idx, 1'b1, 2'b00};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Hclock or posedge Hreset) begin
        if (Hreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = cache_hit ? RESP : ADDR_LO;
                end
            end
            ADDR_LO: begin
                state_nxt = DATA_LO;
            end
            DATA_LO: begin
                if (flash_err) begin
                    state_nxt = RESP;
                end else if (flash_ok) begin
                    state_nxt = DATA_HI;
                end
            end
            DATA_HI: begin
                if (Hready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // The high-half address is issued in the same cycle the low half
    // returns, so Hselect in DATA_LO depends combinationally on Hready.
    // While the low half is stalled the low address stays on the bus.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        Hselect    = 1'b0;
        Haddress   = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            ADDR_LO: begin
                Hselect  = 1'b1;
                Haddress = addr_lo;
            end
            DATA_LO: begin
                Hselect  = flash_ok;
                Haddress = flash_ok ? addr_hi : addr_lo;
            end
            DATA_HI: begin
                Haddress = addr_hi;
            end
            RESP: begin
                resp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign ready      = Hselect;
    assign resp_data  = resp_data_q;
    assign resp_error = resp_error_q;
    assign Hwrite     = 1'b0;
    assign Hsize      = 1'b0;
    assign Hwritedata = '0;

    // ------------------------------------------------------------------
    // Datapath: request word index, low half, response and cache
    // ------------------------------------------------------------------
    always_ff @(posedge Hclock or posedge Hreset) begin
        if (Hreset) begin
            word_idx     <= '0;
            lo_half      <= '0;
            cache_valid  <= 1'b0;
            cache_tag    <= '0;
            cache_data   <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        word_idx <= req_word;
                        if (cache_hit) begin
                            resp_data_q  <= cache_data;
                            resp_error_q <= 1'b0;
                        end
                    end
                end
                DATA_LO: begin
                    if (flash_err) begin
                        resp_data_q  <= '0;
                        resp_error_q <= 1'b1;
                        cache_valid  <= 1'b0;
                    end else if (flash_ok) begin
                        lo_half <= Hreaddata[15:0];
                    end
                end
                DATA_HI: begin
                    if (flash_err) begin
                        resp_data_q  <= '0;
                        resp_error_q <= 1'b1;
                        cache_valid  <= 1'b0;
                    end else if (flash_ok) begin
                        resp_data_q  <= {Hreaddata[15:0], lo_half};
                        resp_error_q <= 1'b0;
                        cache_valid  <= 1'b1;
                        cache_tag    <= word_idx;
                        cache_data   <= {Hreaddata[15:0], lo_half};
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_error_q <= 1'b0;
                    end
                end
                default: begin
                    resp_error_q <= resp_error_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_word_fetch.sv
// ----------------------------------------------------------------------------
// tb_flash_word_fetch
//
// Drives word reads into flash_word_fetch against a behavioural flash model
// with per-access stall and error injection. Expected latency, data, error
// flag and flash access pattern come from a transaction-level model of the
// bridge (word = two halfwords, one-entry cache).
// ----------------------------------------------------------------------------
module tb_flash_word_fetch;

    logic        Hclock = 1'b0;
    logic        Hreset;
    logic        req_valid;
    logic [23:0] req_address;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        Hselect;
    logic        ready;
    logic [23:0] Haddress;
    logic        Hwrite;
    logic        Hsize;
    logic [31:0] Hwritedata;
    logic [31:0] Hreaddata;
    logic        Hready;
    logic        Hresponse;

    flash_word_fetch dut (
        .Hclock      (Hclock),
        .Hreset      (Hreset),
        .req_valid   (req_valid),
        .req_address (req_address),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_error  (resp_error),
        .Hselect     (Hselect),
        .ready       (ready),
        .Haddress    (Haddress),
        .Hwrite      (Hwrite),
        .Hsize       (Hsize),
        .Hwritedata  (Hwritedata),
        .Hreaddata   (Hreaddata),
        .Hready      (Hready),
        .Hresponse   (Hresponse)
    );

    always #5 Hclock = ~Hclock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flash contents: a fixed pattern plus the two halfwords the directed
    // miss test relies on.
    function automatic logic [15:0] hw(input logic [21:0] idx);
        logic [15:0] v;
        if (idx == 22'd8)      v = 16'h1234;
        else if (idx == 22'd9) v = 16'hABCD;
        else                   v = (idx[15:0] * 16'h9E37) ^ {6'h0, idx[21:12]} ^ 16'h5A5A;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Flash model: latches the address when select and strobe are high,
    // then presents data after a configurable number of stall cycles.
    // ------------------------------------------------------------------
    logic        pend;
    logic [21:0] pidx;
    int unsigned stall_left;
    logic        perr;
    int unsigned cfg_stall_lo, cfg_stall_hi;
    logic        cfg_err_lo, cfg_err_hi;
    int unsigned acc_count = 0;
    logic [23:0] iss_q[$];

    always @(posedge Hclock or posedge Hreset) begin
        if (Hreset) begin
            pend       <= 1'b0;
            pidx       <= '0;
            stall_left <= 0;
            perr       <= 1'b0;
        end else if (Hselect && ready) begin
            pend       <= 1'b1;
            pidx       <= Haddress[23:2];
            stall_left <= Haddress[2] ? cfg_stall_hi : cfg_stall_lo;
            perr       <= Haddress[2] ? cfg_err_hi : cfg_err_lo;
            acc_count  <= acc_count + 1;
            iss_q.push_back(Haddress);
        end else if (pend && stall_left == 0) begin
            pend <= 1'b0;
        end else if (pend) begin
            stall_left <= stall_left - 1;
        end
    end

    // Upper data bits carry junk and Hresponse may be high during a stall;
    // neither may influence the bridge.
    assign Hready    = pend && (stall_left == 0);
    assign Hresponse = pend && perr;
    assign Hreaddata = {16'hDEAD ^ pidx[15:0], hw(pidx)};

    // ------------------------------------------------------------------
    // Reference model of the single-entry cache
    // ------------------------------------------------------------------
    logic        m_valid = 1'b0;
    logic [20:0] m_tag   = '0;
    logic [31:0] m_data  = '0;

    task automatic do_req(input logic [23:0] addr, input int unsigned sl, input int unsigned sh,
                          input logic el, input logic eh, input int unsigned bp, input string tag);
        logic [20:0] n;
        logic        hit;
        int unsigned exp_lat, exp_acc, cyc, acc0;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [23:0] lo_addr, hi_addr, a1, a2;

        n       = addr[22:2];
        hit     = m_valid && (m_tag == n);
        lo_addr = {1'b0, n, 1'b0, 2'b00};
        hi_addr = {1'b0, n, 1'b1, 2'b00};
        a1      = '0;
        a2      = '0;
        if (hit) begin
            exp_lat  = 1;
            exp_acc  = 0;
            exp_err  = 1'b0;
            exp_data = m_data;
        end else begin
            exp_err  = el || eh;
            exp_lat  = el ? 3 + sl : 4 + sl + sh;
            exp_acc  = el ? 1 : 2;
            exp_data = exp_err ? 32'h0 : {hw({1'b0, n, 1'b1}), hw({1'b0, n, 1'b0})};
        end

        cfg_stall_lo = sl;
        cfg_stall_hi = sh;
        cfg_err_lo   = el;
        cfg_err_hi   = eh;

        @(negedge Hclock);
        iss_q.delete();
        acc0 = acc_count;
        check({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid   = 1'b1;
        req_address = addr;
        resp_ready  = 1'b0;
        @(posedge Hclock);
        @(negedge Hclock);
        req_valid = 1'b0;
        cyc = 1;
        a1  = Haddress;
        while (!resp_valid && cyc < 60) begin
            @(negedge Hclock);
            cyc++;
            if (cyc == 2) a2 = Haddress;
        end
        check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'h1);
        check({tag, ".resp_data"}, resp_data, exp_data);
        check({tag, ".resp_error"}, {31'h0, resp_error}, {31'h0, exp_err});
        if (!hit && sl == 0) begin
            check({tag, ".addr_cyc1"}, {8'h0, a1}, {8'h0, lo_addr});
            if (!el) check({tag, ".addr_cyc2"}, {8'h0, a2}, {8'h0, hi_addr});
        end

        // Hold the response; stray request pulses must be ignored.
        for (int i = 0; i < int'(bp); i++) begin
            req_valid   = 1'($urandom_range(0, 1));
            req_address = 24'($urandom);
            @(negedge Hclock);
            check({tag, ".bp_valid"}, {31'h0, resp_valid}, 32'h1);
            check({tag, ".bp_req_ready"}, {31'h0, req_ready}, 32'h0);
            check({tag, ".bp_data"}, resp_data, exp_data);
            check({tag, ".bp_error"}, {31'h0, resp_error}, {31'h0, exp_err});
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge Hclock);
        @(negedge Hclock);
        resp_ready = 1'b0;
        check({tag, ".after_valid"}, {31'h0, resp_valid}, 32'h0);
        check({tag, ".after_req_ready"}, {31'h0, req_ready}, 32'h1);
        check({tag, ".after_error"}, {31'h0, resp_error}, 32'h0);

        check({tag, ".accesses"}, acc_count - acc0, exp_acc);
        if (exp_acc >= 1) begin
            check({tag, ".issued_n"}, iss_q.size(), exp_acc);
            if (iss_q.size() >= 1) check({tag, ".issued_lo"}, {8'h0, iss_q[0]}, {8'h0, lo_addr});
            if (exp_acc == 2 && iss_q.size() >= 2)
                check({tag, ".issued_hi"}, {8'h0, iss_q[1]}, {8'h0, hi_addr});
        end

        if (!hit) begin
            if (exp_err) begin
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_tag   = n;
                m_data  = exp_data;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'h0);
        check({tag, ".resp_error"}, {31'h0, resp_error}, 32'h0);
        check({tag, ".resp_data"}, resp_data, 32'h0);
        check({tag, ".Hselect"}, {31'h0, Hselect}, 32'h0);
        check({tag, ".ready"}, {31'h0, ready}, 32'h0);
        check({tag, ".Haddress"}, {8'h0, Haddress}, 32'h0);
        check({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
        check({tag, ".wr_consts"}, {Hwritedata[29:0], Hwrite, Hsize}, 32'h0);
    endtask

    logic [20:0] pool [4];

    initial begin
        Hreset       = 1'b1;
        req_valid    = 1'b0;
        req_address  = '0;
        resp_ready   = 1'b0;
        cfg_stall_lo = 0;
        cfg_stall_hi = 0;
        cfg_err_lo   = 1'b0;
        cfg_err_hi   = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge Hclock);
        Hreset = 1'b0;

        // Directed cases
        do_req(24'h000010, 0, 0, 1'b0, 1'b0, 0, "miss");
        do_req(24'h000013, 0, 0, 1'b0, 1'b0, 0, "hit");
        do_req(24'h800012, 0, 0, 1'b0, 1'b0, 0, "hit_alias");
        do_req(24'h000030, 3, 0, 1'b0, 1'b0, 0, "stall_lo");
        do_req(24'h000050, 0, 0, 1'b0, 1'b1, 0, "err_hi");
        do_req(24'h000050, 0, 1, 1'b0, 1'b0, 0, "err_reread");
        do_req(24'h000060, 1, 0, 1'b1, 1'b0, 0, "err_lo");
        do_req(24'h000050, 0, 0, 1'b0, 1'b0, 5, "bp_hit");
        do_req(24'h000070, 0, 2, 1'b0, 1'b0, 5, "bp_miss");
        do_req(24'h000074, 0, 0, 1'b0, 1'b1, 5, "bp_err");
        do_req(24'h7FFFFC, 0, 0, 1'b0, 1'b0, 0, "top_word");

        // Reset in the middle of a stalled miss
        do_req(24'h000040, 0, 0, 1'b0, 1'b0, 0, "fill");
        cfg_stall_lo = 5;
        @(negedge Hclock);
        req_valid   = 1'b1;
        req_address = 24'h000080;
        @(posedge Hclock);
        @(negedge Hclock);
        req_valid = 1'b0;
        @(negedge Hclock);
        Hreset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        m_valid = 1'b0;
        @(negedge Hclock);
        Hreset = 1'b0;
        do_req(24'h000040, 0, 0, 1'b0, 1'b0, 0, "post_reset");

        // Randomised traffic over a small set of words so hits occur
        pool[0] = 21'd0;
        pool[1] = 21'd1;
        pool[2] = 21'd2;
        pool[3] = 21'h1FFFFF;
        for (int t = 0; t < 60; t++) begin
            logic [23:0] a;
            a = {1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], 2'($urandom_range(0, 3))};
            do_req(a, $urandom_range(0, 2), $urandom_range(0, 2),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 3), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_word_fetch.md
# flash_word_fetch

Bridge between the CPU-side word-read port and the 16-bit flash model. It accepts a 32-bit word read request and issues two halfword accesses on the flash H-bus. It assembles the two halfwords into one word and returns it on a valid/ready response port. A single-entry word cache lets a repeated fetch of the same word skip the flash.

## Interface
Parameters: none.

Ports:
- `Hclock` in 1: sole clock, rising edge.
- `Hreset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: word read request.
- `req_address` in 24: byte address; bits [22:2] select word N; bits [23] and [1:0] are ignored.
- `req_ready` out 1: request accepted when `req_valid` and `req_ready` are both high at a clock edge.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer takes the response.
- `resp_data` out 32: assembled word.
- `resp_error` out 1: flash reported an error for this request.
- `Hselect` out 1: flash select.
- `ready` out 1: address strobe; always equals `Hselect`.
- `Haddress` out 24: flash address; the flash halfword index is `Haddress[23:2]`.
- `Hwrite` out 1: constant 0.
- `Hsize` out 1: constant 0.
- `Hwritedata` out 32: constant 0.
- `Hreaddata` in 32: flash data; only bits [15:0] are used.
- `Hready` in 1: flash data valid.
- `Hresponse` in 1: flash error; sampled only when `Hready` is 1.

## Operation
- Word N is made of halfword 2N (low) and halfword 2N+1 (high): `resp_data = {hw[2N+1], hw[2N]}`.
- Low halfword address: `Haddress = {1'b0, N[20:0], 1'b0, 2'b00}`.
- High halfword address: `Haddress = {1'b0, N[20:0], 1'b1, 2'b00}`.
- State machine states: IDLE, ADDR_LO, DATA_LO, DATA_HI, RESP.
- IDLE:
  - `req_ready` = 1.
  - On accept, N is latched.
  - If the cache entry is valid and its tag equals N (hit): load the cached word, go to RESP.
  - Otherwise go to ADDR_LO.
- ADDR_LO: `Hselect` = `ready` = 1 with the low address. Go to DATA_LO unconditionally.
- DATA_LO:
  - If `Hready` = 0: stay, with `Hselect` = 0.
  - If `Hready` = 1 and `Hresponse` = 1: error abort.
  - If `Hready` = 1 and `Hresponse` = 0: capture `Hreaddata[15:0]` as the low half. In the same cycle drive `Hselect` = `ready` = 1 with the high address, then go to DATA_HI.
- DATA_HI:
  - If `Hready` = 0: stay, with `Hselect` = 0.
  - If `Hready` = 1 and `Hresponse` = 1: error abort.
  - If `Hready` = 1 and `Hresponse` = 0: capture the high half, write the cache (tag = N, valid = 1), go to RESP.
- Error abort: `resp_data` = 0, `resp_error` = 1, cache valid cleared, go to RESP. No further flash access is made for that request.
- RESP:
  - `resp_valid` = 1; `resp_data` and `resp_error` are held stable.
  - When `resp_ready` = 1: go to IDLE and clear `resp_error`.
  - `req_ready` = 0 in every state except IDLE. No new request is accepted in the same cycle the response is taken.
- `Hselect` is 0 in IDLE and RESP.
- `Hwrite`, `Hsize` and `Hwritedata` are always 0.
- The bridge never writes the flash.

## Timing
- Reset (asynchronous; takes effect immediately, including mid-transaction):
  - state = IDLE, cache valid = 0.
  - `resp_valid`, `resp_error`, `resp_data`, `Hselect`, `ready`, `Haddress` = 0.
  - `req_ready` = 1 once in IDLE.
  - Any in-flight response is discarded.
- The flash latches `Haddress` at the edge that ends a cycle with `Hselect` and `ready` both high. Its data is valid in the following cycle.
- Miss latency with `Hready` = 1 (accept edge = cycle 0):
  - cycle 1: ADDR_LO.
  - cycle 2: DATA_LO (low half captured, high address issued).
  - cycle 3: DATA_HI.
  - cycle 4: `resp_valid` = 1.
- Each cycle `Hready` = 0 in DATA_LO or DATA_HI adds one cycle of latency.
- Hit latency: `resp_valid` = 1 in cycle 1; `Hselect` stays 0 throughout.
- Throughput: at most one request per (latency + 1) cycles, because of the RESP → IDLE return.
- Cache tag compare uses the full 21-bit N. Addresses differing only in bit 23 or bits [1:0] alias to the same word.

## Test plan
- Reset behaviour: assert `Hreset` during DATA_LO of a miss → all outputs read 0 at once. After release, `req_ready` = 1. A request to the same address then misses (cache invalid).
- Miss: flash hw[8] = 0x1234, hw[9] = 0xABCD; request `req_address` = 0x000010.
  - cycle 1: `Haddress` = 0x000020.
  - cycle 2: `Haddress` = 0x000024.
  - cycle 4: `resp_valid` = 1, `resp_data` = 0xABCD1234, `resp_error` = 0.
- Hit: repeat 0x000013 after the previous test → `resp_valid` in cycle 1 with 0xABCD1234; `Hselect` never asserted.
- Flash stall: `Hready` = 0 for 3 cycles in DATA_LO → `resp_valid` at cycle 7; data correct; high address issued only once.
- Flash error: `Hresponse` = 1 with `Hready` = 1 in DATA_HI → `resp_error` = 1, `resp_data` = 0. The next request to the same word misses and re-reads both halves.
- Backpressure: hold `resp_ready` = 0 for 5 cycles in RESP → `resp_valid`, `resp_data` and `resp_error` stay constant; `req_ready` = 0; `req_valid` pulses are ignored.
